// File: rtl/mux_pkg.sv
`timescale 1ps/1ps
// Shared constants for the gate-level mux family (mux_2_1, mux4_1 and wider trees).
package mux_pkg;
   localparam int GATE_DELAY_PS = 50;
   localparam int DEFAULT_WIDTH = 1;
endpackage

// File: rtl/dff_ar.sv
`timescale 1ps/1ps
// Single-bit D flip-flop with asynchronous active-high clear.
// Latency one clk edge; reset clears q immediately and holds it while asserted.
module dff_ar (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= 1'b0;
      else       q <= d;
   end
endmodule

// File: rtl/mux_2_1_bit.sv
`timescale 1ps/1ps
// One bit of the 2:1 mux: two AND2 gates feeding an OR2, driven by a shared sel/sel_n pair.
// Data->out is two gate delays; the inverter on sel lives in the parent so all bits share it.
module mux_2_1_bit import mux_pkg::*; #(
   parameter int GATE_DELAY = GATE_DELAY_PS
) (
   input  logic i0,
   input  logic i1,
   input  logic sel,
   input  logic sel_n,
   output logic out
);
   wire a0;
   wire a1;

   and #(GATE_DELAY) u_and0 (a0, i0, sel_n);
   and #(GATE_DELAY) u_and1 (a1, i1, sel);
   or  #(GATE_DELAY) u_or   (out, a0, a1);
endmodule

// File: rtl/mux_2_1.sv
`timescale 1ps/1ps
// Gate-level WIDTH-bit 2:1 mux with a combinational out and a registered out_q (one cycle later).
// Worst-case sel->out is three gate delays; reset clears only out_q, never the combinational path.
module mux_2_1 import mux_pkg::*; #(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int GATE_DELAY = GATE_DELAY_PS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic             sel,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q
);
   wire sel_n;

   not #(GATE_DELAY) u_not_sel (sel_n, sel);

   for (genvar k = 0; k < WIDTH; k++) begin : g_bit
      mux_2_1_bit #(.GATE_DELAY(GATE_DELAY)) u_bit (
         .i0    (i0[k]),
         .i1    (i1[k]),
         .sel   (sel),
         .sel_n (sel_n),
         .out   (out[k])
      );

      dff_ar u_ff (
         .clk   (clk),
         .reset (reset),
         .d     (out[k]),
         .q     (out_q[k])
      );
   end
endmodule

// File: tb/tb_mux_2_1.sv
`timescale 1ps/1ps
// Bench for mux_2_1: scalar and 8-bit instances plus a mux4_1 tree built from three scalar muxes.
module tb_mux_2_1;
   logic clk = 1'b0;
   logic reset;

   logic i0, i1, sel;
   logic out, out_q;

   logic [7:0] a8, b8, out8, out8_q;
   logic       sel8;

   logic [3:0] m_d;
   logic       m_s0, m_s1;
   logic       m_lo, m_hi, m_out;
   logic       m_lo_q, m_hi_q, m_out_q;

   int checks = 0;
   int errors = 0;

   always #5000 clk = ~clk;

   mux_2_1 u_dut (
      .clk(clk), .reset(reset), .i0(i0), .i1(i1), .sel(sel), .out(out), .out_q(out_q)
   );

   mux_2_1 #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .i0(a8), .i1(b8), .sel(sel8), .out(out8), .out_q(out8_q)
   );

   mux_2_1 u_m_lo (
      .clk(clk), .reset(reset), .i0(m_d[0]), .i1(m_d[1]), .sel(m_s0), .out(m_lo), .out_q(m_lo_q)
   );
   mux_2_1 u_m_hi (
      .clk(clk), .reset(reset), .i0(m_d[2]), .i1(m_d[3]), .sel(m_s0), .out(m_hi), .out_q(m_hi_q)
   );
   mux_2_1 u_m_top (
      .clk(clk), .reset(reset), .i0(m_lo), .i1(m_hi), .sel(m_s1), .out(m_out), .out_q(m_out_q)
   );

   task automatic test_reset();
      reset = 1'b1;
      i0 = 1'b1; i1 = 1'b0; sel = 1'b0;
      a8 = 8'h00; b8 = 8'h00; sel8 = 1'b0;
      m_d = 4'h0; m_s0 = 1'b0; m_s1 = 1'b0;
      #100;
      checks++;
      if (out_q !== 1'b0) begin
         errors++; $display("FAIL reset_out_q got %b expected 0", out_q);
      end
      checks++;
      if (out8_q !== 8'h00) begin
         errors++; $display("FAIL reset_out8_q got %h expected 00", out8_q);
      end
      #400;
      checks++;
      if (out !== 1'b1) begin
         errors++; $display("FAIL reset_comb_out got %b expected 1", out);
      end
      checks++;
      if (m_lo_q !== 1'b0 || m_hi_q !== 1'b0 || m_out_q !== 1'b0) begin
         errors++; $display("FAIL reset_tree_q got %b%b%b expected 000", m_lo_q, m_hi_q, m_out_q);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_exhaustive();
      logic exp;
      for (int v = 0; v < 8; v++) begin
         @(negedge clk);
         {sel, i0, i1} = v[2:0];
         exp = sel ? i1 : i0;
         #1000;
         checks++;
         if (out !== exp) begin
            errors++; $display("FAIL exh_out v=%0d got %b expected %b", v, out, exp);
         end
         @(posedge clk);
         #1000;
         checks++;
         if (out_q !== exp) begin
            errors++; $display("FAIL exh_out_q v=%0d got %b expected %b", v, out_q, exp);
         end
      end
   endtask

   task automatic test_delay();
      @(negedge clk);
      i0 = 1'b1; i1 = 1'b0; sel = 1'b0;
      #1000;
      sel = 1'b1;
      #149;
      checks++;
      if (out !== 1'b1) begin
         errors++; $display("FAIL delay_hold_149 got %b expected 1", out);
      end
      #2;
      checks++;
      if (out !== 1'b0) begin
         errors++; $display("FAIL delay_settle_150 got %b expected 0", out);
      end
   endtask

   task automatic test_register();
      @(negedge clk);
      reset = 1'b1;
      #10;
      checks++;
      if (out_q !== 1'b0) begin
         errors++; $display("FAIL reg_reset_immediate got %b expected 0", out_q);
      end
      reset = 1'b0;
      sel = 1'b1; i1 = 1'b1; i0 = 1'b0;
      #1000;
      checks++;
      if (out_q !== 1'b0) begin
         errors++; $display("FAIL reg_before_edge got %b expected 0", out_q);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_q !== 1'b1) begin
         errors++; $display("FAIL reg_after_edge got %b expected 1", out_q);
      end
   endtask

   task automatic test_async_reset();
      #2000;
      reset = 1'b1;
      #10;
      checks++;
      if (out_q !== 1'b0) begin
         errors++; $display("FAIL async_clear got %b expected 0", out_q);
      end
      checks++;
      if (out !== 1'b1) begin
         errors++; $display("FAIL async_comb_kept got %b expected 1", out);
      end
      i1 = 1'b0;
      #200;
      checks++;
      if (out !== 1'b0) begin
         errors++; $display("FAIL async_comb_follows got %b expected 0", out);
      end
      i1 = 1'b1;
      #200;
      reset = 1'b0;
      #100;
      checks++;
      if (out_q !== 1'b0) begin
         errors++; $display("FAIL async_release_hold got %b expected 0", out_q);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_q !== 1'b1) begin
         errors++; $display("FAIL async_release_load got %b expected 1", out_q);
      end
   endtask

   task automatic test_width8();
      @(negedge clk);
      a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b0;
      #1000;
      checks++;
      if (out8 !== 8'hA5) begin
         errors++; $display("FAIL w8_sel0 got %h expected a5", out8);
      end
      sel8 = 1'b1;
      #1000;
      checks++;
      if (out8 !== 8'h3C) begin
         errors++; $display("FAIL w8_sel1 got %h expected 3c", out8);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out8_q !== 8'h3C) begin
         errors++; $display("FAIL w8_out_q got %h expected 3c", out8_q);
      end
   endtask

   task automatic test_equal_inputs();
      @(negedge clk);
      a8 = 8'h5A; b8 = 8'h5A; sel8 = 1'b0;
      #1000;
      for (int g = 0; g < 6; g++) begin
         sel8 = ~sel8;
         #20;
      end
      #500;
      checks++;
      if (out8 !== 8'h5A) begin
         errors++; $display("FAIL equal_glitch got %h expected 5a", out8);
      end
   endtask

   task automatic test_mux4();
      logic [1:0] s;
      logic       exp;
      for (int v = 0; v < 64; v++) begin
         m_d  = v[3:0];
         s    = v[5:4];
         m_s1 = s[1];
         m_s0 = s[0];
         exp  = m_d[s];
         #1000;
         checks++;
         if (m_out !== exp) begin
            errors++; $display("FAIL mux4 v=%0d got %b expected %b", v, m_out, exp);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] exp;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         a8   = 8'($urandom);
         b8   = 8'($urandom);
         sel8 = 1'($urandom_range(1, 0));
         exp  = sel8 ? b8 : a8;
         #1000;
         checks++;
         if (out8 !== exp) begin
            errors++; $display("FAIL rand_out n=%0d got %h expected %h", n, out8, exp);
         end
         @(posedge clk);
         #1;
         checks++;
         if (out8_q !== exp) begin
            errors++; $display("FAIL rand_out_q n=%0d got %h expected %h", n, out8_q, exp);
         end
      end
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog expired got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_exhaustive();
      test_delay();
      test_register();
      test_async_reset();
      test_width8();
      test_equal_inputs();
      test_mux4();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
